// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared constants and types for the load/store access unit:
//   - funct3 size codes, error codes, size and FSM state enums
//   - f3_size(): maps an IR funct3 field to the access size
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The unused funct3 codes (011, 110, 111) fall through to word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// Data memory bus between the access unit (master) and memory (slave).
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : master -> slave
//   mem_ack/mem_rdata                           : slave -> master
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_st_align.sv
// mem_access_unit_st_align
// Combinational size/alignment decode for one access.
//   i_funct3     : IR funct3 field
//   i_addr_lo    : byte address bits [1:0]
//   i_wdata      : right-justified store data
//   o_wdata      : store data shifted onto its byte lanes
//   o_wstrb      : byte-lane strobes for a store
//   o_ld_offset  : offset in access units, for the load-data converter
//   o_misaligned : access violates natural alignment
module mem_access_unit_st_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [1:0]  o_ld_offset,
  output logic        o_misaligned
);

  size_e w_size;

  always_comb begin
    w_size       = f3_size(i_funct3);
    o_wdata      = i_wdata << {i_addr_lo, 3'b000};
    o_wstrb      = 4'b1111;
    o_ld_offset  = 2'b00;
    o_misaligned = |i_addr_lo;
    case (w_size)
      SZ_B: begin
        o_wstrb      = 4'b0001 << i_addr_lo;
        o_ld_offset  = i_addr_lo;
        o_misaligned = 1'b0;
      end
      SZ_H: begin
        o_wstrb      = 4'b0011 << i_addr_lo;
        o_ld_offset  = {1'b0, i_addr_lo[1]};
        o_misaligned = i_addr_lo[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Multi-cycle load/store sequencer: one bus transaction per accepted start,
// bounded by TIMEOUT cycles of waiting for acknowledge.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_start, i_is_store   : request pulse and direction (sampled in IDLE)
//   i_ir, i_addr, i_wdata : instruction (funct3), byte address, store data
//   mem                   : data memory bus (master side)
//   o_ld_data, o_ld_offset: raw read word and access-unit offset
//   o_busy, o_done, o_err : status; err valid with done, held until next start
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | bus request outstanding, counting cycles without ack
// DONE    | one-cycle completion, err valid
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_is_store,
  input  logic [31:0]          i_ir,
  input  logic [31:0]          i_addr,
  input  logic [31:0]          i_wdata,
  mem_access_unit_if.master    mem,
  output logic [31:0]          o_ld_data,
  output logic [1:0]           o_ld_offset,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      r_state;
  state_e      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_ld_data;
  logic [1:0]  r_ld_offset;
  logic [1:0]  r_err;

  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [1:0]  w_ld_offset;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_timeout;
  logic        w_unused;

  assign w_unused = ^{i_ir[31:15], i_ir[11:0]};

  mem_access_unit_st_align u_st_align (
    .i_funct3     (i_ir[14:12]),
    .i_addr_lo    (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_ld_offset  (w_ld_offset),
    .o_misaligned (w_misaligned)
  );

  assign w_accept  = i_start && (r_state == ST_IDLE);
  assign w_timeout = !mem.mem_ack && (r_cnt == TO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_misaligned ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem.mem_ack || w_timeout) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = (r_state == ST_REQ);
    o_busy      = (r_state != ST_IDLE);
    o_done      = (r_state == ST_DONE);
  end

  // Bus fields are only reloaded for aligned accesses so a rejected
  // request never disturbs what the bus last saw.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_ld_data   <= '0;
      r_ld_offset <= '0;
      r_err       <= ERR_OK;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_err <= w_misaligned ? ERR_MISALIGN : ERR_OK;
      if (!w_misaligned) begin
        r_we    <= i_is_store;
        r_addr  <= {i_addr[31:2], 2'b00};
        r_wdata <= i_is_store ? w_wdata : '0;
        r_wstrb <= i_is_store ? w_wstrb : '0;
      end
      if (!i_is_store) r_ld_offset <= w_ld_offset;
    end else if (r_state == ST_REQ) begin
      if (mem.mem_ack) begin
        if (!r_we) r_ld_data <= mem.mem_rdata;
        r_err <= ERR_OK;
      end else begin
        r_cnt <= r_cnt + 8'd1;
        if (w_timeout) r_err <= ERR_TIMEOUT;
      end
    end
  end

  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_wstrb = r_wstrb;
  assign o_ld_data     = r_ld_data;
  assign o_ld_offset   = r_ld_offset;
  assign o_err         = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] ld_data;
  logic [1:0]  ld_offset;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_is_store  (is_store),
    .i_ir        (ir),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .mem         (bus),
    .o_ld_data   (ld_data),
    .o_ld_offset (ld_offset),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns 1 ns after the sampling edge.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    start    = 1'b1;
    is_store = st;
    ir       = {17'h0, f3, 5'h0, (st ? 7'h23 : 7'h03)};
    addr     = a;
    wdata    = wd;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int req_cnt;
    int done_at;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    #12;
    check("rst_req",    32'(bus.mem_req), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_ldata",  ld_data, 32'h0);
    check("rst_addr",   bus.mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LW 0x100, ack in third REQ cycle
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_req",   32'(bus.mem_req), 32'd1);
    check("lw_busy",  32'(busy), 32'd1);
    check("lw_addr",  bus.mem_addr, 32'h100);
    check("lw_we",    32'(bus.mem_we), 32'd0);
    check("lw_strb",  32'(bus.mem_wstrb), 32'h0);
    tick();
    tick();
    check("lw_req3",  32'(bus.mem_req), 32'd1);
    check("lw_ndone", 32'(done), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_ack = 1'b0;
    check("lw_done",  32'(done), 32'd1);
    check("lw_ldata", ld_data, 32'hDEADBEEF);
    check("lw_off",   32'(ld_offset), 32'd0);
    check("lw_err",   32'(err), 32'd0);
    check("lw_reqlo", 32'(bus.mem_req), 32'd0);
    tick();
    check("lw_idle",  32'(busy), 32'd0);
    check("lw_pulse", 32'(done), 32'd0);

    // SB 0x203, immediate ack
    issue(1'b1, 3'b000, 32'h203, 32'h000000A5);
    check("sb_addr",  bus.mem_addr, 32'h200);
    check("sb_wdata", bus.mem_wdata, 32'hA5000000);
    check("sb_strb",  32'(bus.mem_wstrb), 32'h8);
    check("sb_we",    32'(bus.mem_we), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("sb_done",  32'(done), 32'd1);
    check("sb_err",   32'(err), 32'd0);
    tick();

    // LH 0x102 aligned
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h80011234;
    tick();
    bus.mem_ack = 1'b0;
    check("lh_done",  32'(done), 32'd1);
    check("lh_off",   32'(ld_offset), 32'd1);
    check("lh_ldata", ld_data, 32'h80011234);
    tick();

    // LH 0x101 misaligned: done one cycle after start, no request
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    check("mis_req",  32'(bus.mem_req), 32'd0);
    check("mis_done", 32'(done), 32'd1);
    check("mis_err",  32'(err), 32'd1);
    tick();
    check("mis_req2", 32'(bus.mem_req), 32'd0);
    check("mis_idle", 32'(busy), 32'd0);
    check("mis_hold", 32'(err), 32'd1);

    // LW 0x400, no ack: TIMEOUT=4 request cycles then error
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    req_cnt = 0;
    done_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req) req_cnt++;
      if (done) begin
        done_at = i;
        break;
      end
      tick();
    end
    check("to_reqcnt", 32'(req_cnt), 32'd4);
    check("to_doneat", 32'(done_at), 32'd4);
    check("to_err",    32'(err), 32'd2);
    check("to_ldata",  ld_data, 32'h80011234);
    tick();

    // SW 0x500, second start during REQ ignored
    issue(1'b1, 3'b010, 32'h500, 32'h11223344);
    start    = 1'b1;
    is_store = 1'b0;
    addr     = 32'h600;
    wdata    = 32'h0;
    tick();
    start = 1'b0;
    check("ign_addr",  bus.mem_addr, 32'h500);
    check("ign_wdata", bus.mem_wdata, 32'h11223344);
    check("ign_req",   32'(bus.mem_req), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("ign_done",  32'(done), 32'd1);
    // start in the DONE cycle is dropped
    start = 1'b1;
    addr  = 32'h900;
    tick();
    start = 1'b0;
    check("dn_start_busy", 32'(busy), 32'd0);
    check("dn_start_req",  32'(bus.mem_req), 32'd0);
    // ack outside REQ is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_ack = 1'b0;
    check("stray_busy",  32'(busy), 32'd0);
    check("stray_ldata", ld_data, 32'h80011234);

    // reset mid-REQ drops request asynchronously
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    check("rr_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_req0",  32'(bus.mem_req), 32'd0);
    check("rr_busy0", 32'(busy), 32'd0);
    check("rr_done0", 32'(done), 32'd0);
    check("rr_addr0", bus.mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rr_idle", 32'(busy), 32'd0);

    // SH 0x302, then back-to-back LB right after done
    issue(1'b1, 3'b001, 32'h302, 32'h00001234);
    check("sh_wdata", bus.mem_wdata, 32'h12340000);
    check("sh_strb",  32'(bus.mem_wstrb), 32'hC);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("sh_done", 32'(done), 32'd1);
    tick();
    issue(1'b0, 3'b000, 32'h001, 32'h0);
    check("b2b_req",  32'(bus.mem_req), 32'd1);
    check("b2b_addr", bus.mem_addr, 32'h0);
    check("b2b_we",   32'(bus.mem_we), 32'd0);
    check("b2b_strb", 32'(bus.mem_wstrb), 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000AA00;
    tick();
    bus.mem_ack = 1'b0;
    check("b2b_done",  32'(done), 32'd1);
    check("b2b_off",   32'(ld_offset), 32'd1);
    check("b2b_ldata", ld_data, 32'h0000AA00);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store sequencer between the core datapath and the data memory bus.
- On a start pulse it decodes size from IR funct3 and checks alignment, then issues one bus transaction and waits for acknowledge.
- It waits at most TIMEOUT cycles. On a load, it returns the raw 32-bit word plus an access-unit offset to the downstream load-data converter. On a store, it drives lane-aligned write data and byte strobes.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ack before aborting with error (range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request pulse; ignored unless busy=0
is_store  in  1  1=store, 0=load; sampled with start
ir  in  32  instruction register; funct3 = ir[14:12] sampled with start
addr  in  32  effective byte address; sampled with start
wdata  in  32  store source data, right-justified; sampled with start
mem_req  out  1  bus request, held until ack or timeout
mem_we  out  1  1=write
mem_addr  out  32  word address: {addr[31:2],2'b00}
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  byte-lane strobes, writes only; 0 for reads
mem_ack  in  1  bus acknowledge, single cycle
mem_rdata  in  32  read data, valid with mem_ack
ld_data  out  32  latched raw read word
ld_offset  out  2  access-unit offset for converter
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
err  out  2  0=ok, 1=misaligned, 2=timeout; valid with done, held until next start

Behaviour:
- Reset (async, reset=0) clears all outputs and registers to 0 and sets state IDLE. Reset asserted mid-transaction drops mem_req immediately.
- Size decode from funct3[1:0]: 00=byte, 01=half, 10=word. funct3=011, 110 or 111 is treated as word.
- Alignment rules:
  - byte: always aligned.
  - half: addr[0]=0 required.
  - word: addr[1:0]=0 required.
- ld_offset encoding:
  - byte: addr[1:0].
  - half: {1'b0,addr[1]}.
  - word: 0.
- Store lanes (wdata shifted left by 8*addr[1:0]):
  - byte: wstrb = 0001<<addr[1:0].
  - half: wstrb = 0011<<addr[1:0].
  - word: wstrb = 1111.
- IDLE: busy=0, mem_req=0. On start:
  - Latch the inputs and compute ld_offset.
  - If misaligned: go to DONE with err=1; no bus activity.
  - Otherwise: go to REQ, with busy=1 from the next cycle.
- REQ:
  - mem_req=1; mem_we/addr/wdata/wstrb stable while mem_req=1.
  - Timeout counter clears on entry and increments each cycle mem_ack=0.
  - mem_ack=1: on a load, ld_data<=mem_rdata; err=0; go to DONE. The ack cycle itself may be the first REQ cycle.
  - Counter reaches TIMEOUT-1 without ack: go to DONE, err=2, ld_data unchanged.
- DONE: done=1 for exactly one cycle, busy=1, mem_req=0; then IDLE.
- Minimum latency, start to done:
  - 2 cycles with ack in the first REQ cycle.
  - 1 cycle for a misaligned access.
- Start while busy=1 is ignored. Start in the same cycle as the DONE→IDLE transition is ignored; accepted from IDLE only.
- mem_ack outside REQ is ignored.
- ld_data/ld_offset hold until the next accepted load.
- Counter width is 8 bits.

Decomposition:
- Shared package holds:
  - funct3 size constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - err codes: ERR_OK, ERR_MISALIGN, ERR_TIMEOUT.
  - FSM state encoding: IDLE, REQ, DONE.
- One natural combinational sub-module, st_align: (funct3, addr[1:0], wdata) → mem_wdata, mem_wstrb, ld_offset, misaligned.
- FSM and counter stay in the top module.

Test Plan:
- Load LW, addr=0x100, ack on 3rd REQ cycle with rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0, wstrb=0, ld_data=0xDEADBEEF, ld_offset=0, err=0, done 4 cycles after start.
- Store SB, addr=0x203, wdata=0x000000A5, immediate ack → mem_addr=0x200, wdata=0xA5000000, wstrb=1000, done 2 cycles after start.
- LH addr=0x102 with ack, rdata=0x8001xxxx → ld_offset=01. LH addr=0x101 → err=1, no mem_req ever, done 1 cycle after start.
- Load with no ack, TIMEOUT=4 → mem_req high exactly 4 cycles, then done with err=2, ld_data unchanged.
- Start pulsed again while in REQ with a different addr → ignored; mem_addr unchanged. Reset driven low mid-REQ → mem_req, busy, done go 0 immediately, state IDLE.
- SH addr=0x302, wdata=0x1234 → wdata=0x12340000, wstrb=1100. Back-to-back start the cycle after done → accepted.
